// File: rtl/mwadd_pkg.sv
// rtl/mwadd_pkg.sv - shared types and constants for the multiword sequential adder
package mwadd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mwadd_state_e;

   localparam int MWADD_SLICE_W = 16;

   // A single-slice build still needs a 1-bit index register.
   function automatic int mwadd_idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 16-bit Kogge-Stone prefix adder
module adder (
   output logic        cout,
   output logic [15:0] sum,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin
);

   // One prefix level: combine each bit with the bit d places below it.
   function automatic logic [31:0] ks_step(input logic [15:0] g, input logic [15:0] p, input int d);
      logic [15:0] g_n;
      logic [15:0] p_n;
      g_n = g;
      p_n = p;
      for (int i = 0; i < 16; i++) begin
         if (i >= d) begin
            g_n[i] = g[i] | (p[i] & g[i-d]);
            p_n[i] = p[i] & p[i-d];
         end
      end
      return {g_n, p_n};
   endfunction

   logic [15:0] p0, g0, p1, g1, p2, g2, p3, g3, p4, g4;

   // Folding cin into bit 0's generate makes every prefix a true carry.
   always_comb begin
      p0    = a ^ b;
      g0    = a & b;
      g0[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
   end

   assign {g1, p1} = ks_step(g0, p0, 1);
   assign {g2, p2} = ks_step(g1, p1, 2);
   assign {g3, p3} = ks_step(g2, p2, 4);
   assign {g4, p4} = ks_step(g3, p3, 8);

   assign sum  = p0 ^ {g4[14:0], cin};
   assign cout = g4[15];

endmodule

// File: rtl/multiword_adder_seq.sv
// rtl/multiword_adder_seq.sv - WORDS x 16-bit adder, one slice per cycle
// Optional subtraction support under macro MWADD_SUB_EN.
module multiword_adder_seq
   import mwadd_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [MWADD_SLICE_W*WORDS-1:0] a,
   input  logic [MWADD_SLICE_W*WORDS-1:0] b,
   input  logic                           cin,
`ifdef MWADD_SUB_EN
   input  logic                           sub,
`endif
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [MWADD_SLICE_W*WORDS-1:0] sum,
   output logic                           cout
);

   localparam int W  = MWADD_SLICE_W * WORDS;
   localparam int IW = mwadd_idx_w(WORDS);

   mwadd_state_e state_q, state_d;

   logic [IW-1:0]            idx;
   logic [W-1:0]             a_reg, b_reg, sum_reg, sum_nxt, sum_q;
   logic                     carry_reg, cout_q;
   logic                     last_slice;
   logic [MWADD_SLICE_W-1:0] a_sl, b_raw, b_sl, add_sum;
   logic                     add_cout;

   assign last_slice = (idx == IW'(WORDS - 1));
   assign a_sl       = a_reg[MWADD_SLICE_W*idx +: MWADD_SLICE_W];
   assign b_raw      = b_reg[MWADD_SLICE_W*idx +: MWADD_SLICE_W];

`ifdef MWADD_SUB_EN
   logic sub_reg;
   assign b_sl = sub_reg ? ~b_raw : b_raw;
`else
   assign b_sl = b_raw;
`endif

   adder u_adder (
      .cout (add_cout),
      .sum  (add_sum),
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_reg)
   );

   always_comb begin
      sum_nxt = sum_reg;
      sum_nxt[MWADD_SLICE_W*idx +: MWADD_SLICE_W] = add_sum;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
`ifdef MWADD_SUB_EN
         sub_reg   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  idx   <= '0;
`ifdef MWADD_SUB_EN
                  sub_reg   <= sub;
                  carry_reg <= sub | cin & ~sub;
`else
                  carry_reg <= cin;
`endif
               end
            end
            RUN: begin
               sum_reg   <= sum_nxt;
               carry_reg <= add_cout;
               // Visible result only updates once the whole word is done.
               if (last_slice) begin
                  idx    <= '0;
                  sum_q  <= sum_nxt;
                  cout_q <= add_cout;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule
